// File: rtl/mmio_io_hub.sv
// Memory-mapped game I/O hub: LFSR random source, LED command/status, and a
// debounced button event register with clear-on-read, muxed over RAM read data.
module mmio_io_hub #(
  parameter int          N_CH            = 4,
  parameter logic [11:0] BASE_ADDR       = 12'd5,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          FLASH_CYCLES    = 25000000,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [11:0]     addr,
  input  logic            wren,
  input  logic            rden,
  input  logic [31:0]     data_in,
  input  logic [31:0]     ram_q,
  output logic [31:0]     q_out,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] leds,
  output logic            irq_pending
);

  localparam int CHW = $clog2(N_CH);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int FW  = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FL_LAST   = FW'(FLASH_CYCLES - 1);
  localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

  // Galois step for x^32 + x^22 + x^2 + x + 1, shifting toward bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  logic [N_CH-1:0] sync0_q, sync1_q, db_q, db_d, press_s;
  logic [DW-1:0]   db_cnt_q [N_CH];
  logic [DW-1:0]   db_cnt_d [N_CH];
  logic            valid_q, valid_d, ovf_q, ovf_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [3:0]      idx_q, idx_d, first_s;
  logic [N_CH-1:0] on_q, on_d, flash_q, flash_d;
  logic [FW-1:0]   fcnt_q [N_CH];
  logic [FW-1:0]   fcnt_d [N_CH];
  logic [31:0]     lfsr_q, lfsr_d, hub_rd_s;

  logic [11:0]     off_s;
  logic            in_win_s, wr_rand_s, wr_led_s, clr_evt_s, chan_ok_s;
  logic [CHW-1:0]  chan_s;
  logic [1:0]      mode_s;

  assign off_s     = addr - BASE_ADDR;
  assign in_win_s  = (off_s < 12'd4);
  assign wr_rand_s = wren && in_win_s && (off_s[1:0] == 2'd0) && (data_in != 32'd0);
  assign wr_led_s  = wren && in_win_s && (off_s[1:0] == 2'd1);
  assign clr_evt_s = rden && in_win_s && (off_s[1:0] == 2'd2);
  assign chan_s    = data_in[CHW+1:2];
  assign mode_s    = data_in[1:0];
  assign chan_ok_s = (5'(chan_s) < 5'(N_CH));

  // Debounce: a press is the cycle the accepted level rises.
  always_comb begin
    db_d    = db_q;
    press_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      db_cnt_d[i] = '0;
      if (sync1_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]    = sync1_q[i];
          press_s[i] = sync1_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Event register; a press coincident with a clearing read reloads it fresh.
  always_comb begin
    first_s = 4'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_s[i]) begin
        first_s = 4'(i);
      end else begin
        first_s = first_s;
      end
    end
    valid_d = valid_q;
    ovf_d   = ovf_q;
    mask_d  = mask_q | press_s;
    idx_d   = idx_q;
    if (clr_evt_s) begin
      valid_d = |press_s;
      ovf_d   = 1'b0;
      mask_d  = press_s;
      idx_d   = first_s;
    end else if (|press_s) begin
      if (valid_q) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        idx_d   = first_s;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // LED state: flash countdown first, then any command for this channel wins.
  always_comb begin
    on_d    = on_q;
    flash_d = flash_q;
    for (int i = 0; i < N_CH; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (flash_q[i]) begin
        if (fcnt_q[i] == '0) begin
          on_d[i]    = 1'b0;
          flash_d[i] = 1'b0;
        end else begin
          fcnt_d[i] = fcnt_q[i] - FW'(1);
        end
      end else begin
        fcnt_d[i] = fcnt_q[i];
      end
      if (wr_led_s && chan_ok_s && (chan_s == CHW'(i))) begin
        flash_d[i] = 1'b0;
        fcnt_d[i]  = '0;
        case (mode_s)
          2'b00:   on_d[i] = 1'b0;
          2'b01:   on_d[i] = 1'b1;
          2'b10: begin
            on_d[i]    = 1'b1;
            flash_d[i] = 1'b1;
            fcnt_d[i]  = FL_LAST;
          end
          2'b11:   on_d[i] = ~on_q[i];
          default: on_d[i] = on_q[i];
        endcase
      end else begin
        on_d[i] = on_d[i];
      end
    end
  end

  assign lfsr_d = wr_rand_s ? data_in : lfsr_step(lfsr_q);

  // Combinational read mux over RAM data.
  always_comb begin
    case (off_s[1:0])
      2'd0:    hub_rd_s = lfsr_q;
      2'd1:    hub_rd_s = 32'd0;
      2'd2:    hub_rd_s = {valid_q, ovf_q, 6'd0, 16'(mask_q), 4'd0, idx_q};
      2'd3:    hub_rd_s = 32'(on_q);
      default: hub_rd_s = 32'd0;
    endcase
    if (in_win_s) begin
      q_out = hub_rd_s;
    end else begin
      q_out = ram_q;
    end
  end

  assign leds        = on_q;
  assign irq_pending = valid_q;

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      db_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      mask_q  <= '0;
      idx_q   <= 4'd0;
      on_q    <= '0;
      flash_q <= '0;
      lfsr_q  <= LFSR_SEED;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i] <= '0;
        fcnt_q[i]   <= '0;
      end
    end else begin
      sync0_q <= buttons;
      sync1_q <= sync0_q;
      db_q    <= db_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      flash_q <= flash_d;
      lfsr_q  <= lfsr_d;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        fcnt_q[i]   <= fcnt_d[i];
      end
    end
  end

endmodule
